// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  // Misaligned halfword/word accesses and the unused size code are rejected.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      SZ_WORD: return (a_lo != 2'b00);
      SZ_HALF: return a_lo[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_cnt <= '0;
    else if (inc && (r_cnt != W'(MAX)))
      r_cnt <= r_cnt + 1'b1;
  end

  assign at_max = (r_cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Request/grant arbiter for the single-ported unified memory: data has priority,
// a streak counter forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_half,
  output logic              mem_byte,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e              r_state, w_next;
  logic                r_own, r_we, r_err;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [LAT_W-1:0]    r_lat_cnt;

  logic w_arb, w_d_win, w_f_win, w_d_err, w_at_max;
  logic w_busy, w_resp, w_last;

  // Arbitration is open in IDLE and RESP so accesses issue back to back.
  assign w_arb   = !rst && (r_state != ST_BUSY);
  assign w_d_win = w_arb && d_req && !(if_req && w_at_max);
  assign w_f_win = w_arb && if_req && !w_d_win;
  assign w_d_err = size_err(d_size, d_addr[1:0]);
  assign w_busy  = (r_state == ST_BUSY);
  assign w_last  = w_busy && (r_lat_cnt == '0);
  assign w_resp  = (r_state == ST_RESP) && !rst;

  assign d_gnt  = w_d_win;
  assign if_gnt = w_f_win;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_d_win && if_req),
    .clr    (w_f_win || (w_d_win && !if_req)),
    .at_max (w_at_max)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_d_win)
          w_next = w_d_err ? ST_RESP : ST_BUSY;
        else if (w_f_win)
          w_next = ST_BUSY;
        else
          w_next = ST_IDLE;
      end
      ST_BUSY: if (w_last) w_next = ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_own     <= OWN_IF;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_size    <= SZ_WORD;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (w_d_win) begin
        r_own   <= OWN_D;
        r_we    <= d_we && !w_d_err;
        r_err   <= w_d_err;
        r_size  <= d_size;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
      end else if (w_f_win) begin
        r_own   <= OWN_IF;
        r_we    <= 1'b0;
        r_err   <= 1'b0;
        r_size  <= SZ_WORD;
        r_addr  <= if_addr;
        r_wdata <= '0;
      end
      if (w_d_win || w_f_win)
        r_lat_cnt <= LAT_W'(MEM_LAT - 1);
      else if (w_busy && !w_last)
        r_lat_cnt <= r_lat_cnt - 1'b1;
      if (w_last)
        r_rdata <= mem_rdata;
    end
  end

  // Memory command comes only from the latched request, and only while BUSY.
  assign busy      = w_busy;
  assign mem_addr  = w_busy ? r_addr : '0;
  assign mem_read  = w_busy && !r_we;
  assign mem_write = w_busy && r_we;
  assign mem_half  = w_busy && (r_size == SZ_HALF);
  assign mem_byte  = w_busy && (r_size == SZ_BYTE);
  assign mem_wdata = w_busy ? r_wdata : '0;

  assign if_rvalid = w_resp && (r_own == OWN_IF);
  assign if_rdata  = if_rvalid ? r_rdata : '0;
  assign d_rvalid  = w_resp && (r_own == OWN_D);
  assign d_err     = d_rvalid && r_err;
  assign d_rdata   = (d_rvalid && !r_we && !r_err) ? r_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench against a cycle-number transaction model.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_half, mem_byte, busy;

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = memfn(mem_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_half(mem_half),
    .mem_byte(mem_byte), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  int cyc, arb_ok, streak, t_g, d_run, d_run_max;
  bit have, t_own_d, t_we, t_err, s_if_g, s_d_g;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: check every output against the model, then advance the model.
  task automatic step();
    bit e_dg, e_fg, inwin, resp;
    @(negedge clk);
    e_dg  = !rst && cyc >= arb_ok && d_req && !(if_req && streak >= SMAX);
    e_fg  = !rst && cyc >= arb_ok && if_req && !e_dg;
    inwin = have && !t_err && cyc > t_g && cyc <= t_g + LAT;
    resp  = !rst && have && cyc == t_g + (t_err ? 1 : LAT + 1);
    chk("if_gnt",    64'(if_gnt),    64'(e_fg));
    chk("d_gnt",     64'(d_gnt),     64'(e_dg));
    chk("busy",      64'(busy),      64'(inwin));
    chk("mem_read",  64'(mem_read),  64'(inwin && !t_we));
    chk("mem_write", 64'(mem_write), 64'(inwin && t_we));
    chk("mem_half",  64'(mem_half),  64'(inwin && t_size == 2'b10));
    chk("mem_byte",  64'(mem_byte),  64'(inwin && t_size == 2'b01));
    chk("mem_addr",  64'(mem_addr),  64'(inwin ? t_addr : 32'h0));
    chk("mem_wdata", 64'(mem_wdata), 64'(inwin ? t_wdata : 32'h0));
    chk("if_rvalid", 64'(if_rvalid), 64'(resp && !t_own_d));
    chk("if_rdata",  64'(if_rdata),  64'((resp && !t_own_d) ? memfn(t_addr) : 32'h0));
    chk("d_rvalid",  64'(d_rvalid),  64'(resp && t_own_d));
    chk("d_err",     64'(d_err),     64'(resp && t_own_d && t_err));
    chk("d_rdata",   64'(d_rdata),
        64'((resp && t_own_d && !t_we && !t_err) ? memfn(t_addr) : 32'h0));
    if (d_gnt && if_req) d_run++;
    else if (if_gnt || !if_req || rst) d_run = 0;
    if (d_run > d_run_max) d_run_max = d_run;
    if (rst) begin
      have = 0; streak = 0; arb_ok = cyc + 1;
    end else if (e_dg || e_fg) begin
      have    = 1;
      t_g     = cyc;
      t_own_d = e_dg;
      t_addr  = e_dg ? d_addr : if_addr;
      t_we    = e_dg && d_we;
      t_size  = e_dg ? d_size : 2'b00;
      t_wdata = e_dg ? d_wdata : 32'h0;
      t_err   = e_dg && (d_size == 2'b11 || (d_size == 2'b10 && d_addr[0]) ||
                         (d_size == 2'b00 && d_addr[1:0] != 2'b00));
      arb_ok  = cyc + (t_err ? 1 : LAT + 1);
      if (e_fg)        streak = 0;
      else if (if_req) streak = (streak < SMAX) ? streak + 1 : SMAX;
      else             streak = 0;
    end
    s_if_g = if_gnt;
    s_d_g  = d_gnt;
    @(posedge clk); #1;
    cyc++;
  endtask

  // Requesters drop their request once granted.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (s_if_g) if_req = 1'b0;
      if (s_d_g)  d_req  = 1'b0;
    end
  endtask

  task automatic set_d(input bit we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    cyc = 0; arb_ok = 0; streak = 0; t_g = 0; have = 0; t_own_d = 0; t_we = 0; t_err = 0;
    t_size = 0; t_addr = 0; t_wdata = 0; d_run = 0; d_run_max = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(2);

    if_req = 1; if_addr = 32'h10;
    run(5);

    if_req = 1; if_addr = 32'h20;
    set_d(0, 2'b00, 32'h100, 32'h0);
    run(10);

    if_req = 1; if_addr = 32'h400;
    set_d(0, 2'b00, 32'h800, 32'h0);
    for (int i = 0; i < 60; i++) begin
      step();
      if (s_if_g) if_addr += 4;
      if (s_d_g)  d_addr  += 4;
    end
    if_req = 0; d_req = 0;
    run(6);

    set_d(0, 2'b10, 32'h101, 32'h0); run(4);
    set_d(0, 2'b00, 32'h102, 32'h0); run(4);
    set_d(1, 2'b11, 32'h100, 32'h5); run(4);
    set_d(0, 2'b10, 32'h102, 32'h0); run(6);
    set_d(1, 2'b01, 32'h203, 32'hAB); run(6);

    set_d(1, 2'b00, 32'h40, 32'h1234);
    run(1);
    rst = 1'b1; run(1); rst = 1'b0;
    run(6);

    for (int i = 0; i < 3000; i++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom_range(0, 1023);
      end else if (if_req && $urandom_range(0, 49) == 0) if_req = 0;
      if (!d_req && $urandom_range(0, 1) == 0)
        set_d($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1023), $urandom);
      else if (d_req && $urandom_range(0, 49) == 0) d_req = 0;
      rst = ($urandom_range(0, 299) == 0);
      step();
      if (s_if_g) if_req = 1'b0;
      if (s_d_g)  d_req  = 1'b0;
    end
    rst = 0; if_req = 0; d_req = 0;
    run(6);

    chk("starve_run_le_max", 64'(d_run_max <= SMAX), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
